aes_inv_cipher_iter: RTL
========================

Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher (decryption) datapath: one inverse round per clock; this is the decrypt-side counterpart of the pipelined encrypt rounds.
- Takes one 128-bit ciphertext block and produces the plaintext.
- Round keys are not expanded here. The block drives a round-key index, and an external key store returns that round key combinationally in the same cycle.
- Sits between the key-schedule RAM and the block-mode wrapper; valid/ready on both sides.

Parameters:
- NR, 10, number of rounds. Legal values are 10, 12, 14 (AES-128/192/256); the datapath is identical, only the count changes.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ct_in is valid
- in_ready  out  1  block can accept ct_in (high only in IDLE)
- ct_in  in  128  ciphertext; bits 127:120 = FIPS-197 byte 0, column-major
- rk_idx  out  4  round-key index requested this cycle
- rk_in  in  128  round key for rk_idx, valid in the same cycle; same byte order as ct_in
- out_valid  out  1  pt_out valid
- out_ready  in  1  downstream accepts pt_out
- pt_out  out  128  plaintext, same byte order
- busy  out  1  high in RUN or DONE

Behaviour:
- FSM states: IDLE, RUN, DONE. Internal registers: st[127:0] and rnd[3:0].
- IDLE:
  - in_ready=1, rk_idx=NR.
  - On in_valid: st <= ct_in ^ rk_in, rnd <= NR-1, go to RUN.
- RUN:
  - rk_idx=rnd.
  - t = InvSubBytes(InvShiftRows(st)) ^ rk_in. InvShiftRows rotates row r right by r bytes.
  - If rnd!=0: st <= InvMixColumns(t), rnd <= rnd-1.
  - If rnd==0: pt_out <= t, go to DONE.
  - InvMixColumns uses GF(2^8) with poly 0x11B and coefficient matrix {0e,0b,0d,09} circulant, built from an xtime chain. No multipliers, no ROM.
  - InvSubBytes: 16 combinational inverse S-box lookups (256-entry table).
- DONE:
  - out_valid=1; pt_out stable until accepted.
  - On out_ready: go to IDLE.
  - No input accept in DONE, even if out_ready=1 in that cycle. The next block is accepted at the earliest 1 cycle later.
- Latency: the accept edge is cycle 0. out_valid goes high after the edge at cycle NR (10 for NR=10). rk_idx sequence from accept onward is NR, NR-1, ..., 0.
- Throughput: at most one block per NR+2 cycles when out_ready is held high.
- rk_in is sampled only while in_valid&&in_ready (IDLE) or in RUN. It is ignored elsewhere.
- in_valid while busy: ignored; ct_in is not latched. The upstream must hold it until in_ready.
- out_valid, once high, stays high with pt_out unchanged until out_ready (no retraction).
- Reset, any state including mid-RUN or DONE, takes effect at the next edge:
  - state=IDLE, out_valid=0, pt_out=0, st=0, rnd=0, busy=0, in_ready=1, rk_idx=NR.
  - A partial result is discarded; no out_valid pulse.
- in_ready, out_valid, busy and rk_idx decode from FSM state/rnd only. No combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset check: assert rst for 2 cycles with in_valid=1 → during and after reset: in_ready=1, out_valid=0, pt_out=0, busy=0, rk_idx=10.
- FIPS-197 C.1, NR=10: key 000102030405060708090a0b0c0d0e0f (bench key model serves rk_in); ct 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 → out_valid at cycle 10; pt_out=00112233445566778899aabbccddeeff; rk_idx trace 10..0.
- Back-pressure plus busy input: after the C.1 accept, drive in_valid with another ct for the whole run. Hold out_ready=0 for 5 cycles after out_valid → pt_out is stable, the second ct is not accepted until in_ready returns, and the second result is correct.
- Back-to-back: FIPS-197 App. B, key 2b7e151628aed2a6abf7158809cf4f3c. ct 3925841d02dc09fbdc118597196a0b32 → 3243f6a8885a308d313198a2e0370734. Followed immediately by C.1 → both correct; accept edges are 12 cycles apart.
- Reset mid-operation: assert rst at RUN cycle 5 of a C.1 decrypt → no out_valid. The next C.1 decrypt gives the correct plaintext with normal latency.
- NR=14 instance: FIPS-197 C.3, key 000102...1f, ct 8ea2b7ca516745bfeafc49904b496089 → pt 00112233445566778899aabbccddeeff at cycle 14.

Source files
------------

// File: rtl/aes_inv_cipher_iter_if.sv
// rtl/aes_inv_cipher_iter_if.sv - handshake and key-store bundle for the iterative AES inverse cipher
//
// Signals:
//   in_valid/in_ready/ct_in    ciphertext input handshake (128-bit, byte 0 in bits 127:120)
//   rk_idx/rk_in               round-key request and same-cycle key-store response
//   out_valid/out_ready/pt_out plaintext output handshake
//   busy                       cipher is in RUN or DONE
// Modports: master = upstream/key store/downstream side, slave = cipher core.
interface aes_inv_cipher_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;

  modport master (
    output in_valid, ct_in, rk_in, out_ready,
    input  in_ready, rk_idx, out_valid, pt_out, busy
  );

  modport slave (
    input  in_valid, ct_in, rk_in, out_ready,
    output in_ready, rk_idx, out_valid, pt_out, busy
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES inverse cipher, one inverse round per clock
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  aes_inv_cipher_iter_if.slave: ciphertext in, round-key request/response,
//        plaintext out, busy
// Parameter NR: 10, 12 or 14 rounds (AES-128/192/256).
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  aes_inv_cipher_iter_if.slave     bus
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  // Inverse S-box, entry 0 is the leftmost byte.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [127:0] st;
  logic [127:0] pt_q;
  logic [3:0]   rnd;
  logic [127:0] t;
  logic [127:0] imc;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One InvMixColumns column; x2/x4/x8 chain gives 9, b, d, e by XOR.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // Round datapath: byte (r,c) of t comes from byte (r, c-r mod 4) of st.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      localparam int DST = r + 4 * c;
      assign t[127-8*DST -: 8] = INV_SBOX[st[127-8*SRC -: 8]] ^ bus.rk_in[127-8*DST -: 8];
    end
    assign imc[127-32*c -: 32] = inv_mix_col(t[127-32*c -: 32]);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (rnd == 4'd0)   state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    bus.rk_idx    = (state == RUN) ? rnd : NR_IDX;
    bus.pt_out    = pt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= '0;
      rnd  <= '0;
      pt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            st  <= bus.ct_in ^ bus.rk_in;
            rnd <= NR_IDX - 4'd1;
          end
        end
        RUN: begin
          if (rnd != 4'd0) begin
            st  <= imc;
            rnd <= rnd - 4'd1;
          end else begin
            pt_q <= t;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
